// File: rtl/wash_pkg.sv
// Shared types and program preset tables for the washer controller and its phase timer.
package wash_pkg;

   typedef enum logic [2:0] {
      T_IDLE      = 3'd0,
      T_WASH      = 3'd1,
      T_HOLD      = 3'd2,
      T_WASH_DONE = 3'd3,
      T_DRY       = 3'd4,
      T_DRY_DONE  = 3'd5
   } timer_state_t;

   // Durations are in timer ticks, indexed by the 2-bit program select.
   localparam int WASH_PRESET [4] = '{10, 20, 30, 45};
   localparam int DRY_PRESET  [4] = '{5, 10, 15, 20};

   typedef enum logic [2:0] {
      W_IDLE  = 3'd0,
      W_FILL  = 3'd1,
      W_WASH  = 3'd2,
      W_PAUSE = 3'd3,
      W_DRY   = 3'd4,
      W_DONE  = 3'd5
   } washer_state_t;

endpackage

// File: rtl/wash_timer_prescaler.sv
// Clock divider: emits a one-cycle tick on every TICK_DIV-th enabled cycle.
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] count;

   assign tick = enable && (count == LAST);

   // Count only while enabled so a frozen phase resumes mid-tick without loss.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + PW'(1);
      end
   end

endmodule

// File: rtl/wash_timer.sv
// Wash/dry phase timer: counts down per-program durations and raises the
// registered completion strobes consumed by the washer control FSM.
module wash_timer
   import wash_pkg::*;
#(
   parameter int TICK_DIV = 1000,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       prog,
   input  logic             clear,
   input  logic             water_pump,
   input  logic             drying_fan,
   input  logic             paused,
   output logic             comp_time,
   output logic             comp_time2,
   output logic [CNT_W-1:0] remaining,
   output logic [2:0]       phase
);

   timer_state_t     state, next_state;
   logic [CNT_W-1:0] wash_cnt, dry_cnt;
   logic             wash_run, dry_run, presc_clr, tick;
   logic             comp_next, comp2_next;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (wash_run | dry_run),
      .clear  (presc_clr),
      .tick   (tick)
   );

   // Zero-count checks come before pause/gating so an elapsed phase always completes.
   always_comb begin
      next_state = state;
      wash_run   = 1'b0;
      dry_run    = 1'b0;
      presc_clr  = 1'b0;
      comp_next  = comp_time;
      comp2_next = comp_time2;
      if (clear) begin
         next_state = T_IDLE;
         presc_clr  = 1'b1;
         comp_next  = 1'b0;
         comp2_next = 1'b0;
      end else begin
         case (state)
            T_IDLE: begin
               if (water_pump) begin
                  next_state = T_WASH;
                  wash_run   = !paused;
               end else if (drying_fan) begin
                  next_state = T_DRY;
                  dry_run    = 1'b1;
               end
            end
            T_WASH: begin
               if (wash_cnt == '0) begin
                  comp_next  = 1'b1;
                  next_state = T_WASH_DONE;
               end else if (paused || !water_pump) begin
                  next_state = T_HOLD;
               end else begin
                  wash_run = 1'b1;
               end
            end
            T_HOLD: begin
               if (water_pump && !paused) begin
                  next_state = T_WASH;
                  wash_run   = 1'b1;
               end
            end
            T_WASH_DONE: begin
               if (drying_fan) begin
                  next_state = T_DRY;
                  presc_clr  = 1'b1;
                  comp_next  = 1'b0;
               end
            end
            T_DRY: begin
               if (dry_cnt == '0) begin
                  comp2_next = 1'b1;
                  next_state = T_DRY_DONE;
               end else if (drying_fan) begin
                  dry_run = 1'b1;
               end
            end
            T_DRY_DONE: ;
            default: next_state = T_IDLE;
         endcase
      end
   end

   // Presets are loaded only on clear, which is what latches the program.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= T_IDLE;
         wash_cnt   <= CNT_W'(WASH_PRESET[0]);
         dry_cnt    <= CNT_W'(DRY_PRESET[0]);
         comp_time  <= 1'b0;
         comp_time2 <= 1'b0;
      end else begin
         state      <= next_state;
         comp_time  <= comp_next;
         comp_time2 <= comp2_next;
         if (clear) begin
            wash_cnt <= CNT_W'(WASH_PRESET[prog]);
            dry_cnt  <= CNT_W'(DRY_PRESET[prog]);
         end else begin
            if (wash_run && tick && wash_cnt != '0)
               wash_cnt <= wash_cnt - CNT_W'(1);
            if (dry_run && tick && dry_cnt != '0)
               dry_cnt <= dry_cnt - CNT_W'(1);
         end
      end
   end

   always_comb begin
      remaining = '0;
      case (state)
         T_WASH, T_HOLD, T_WASH_DONE: remaining = wash_cnt;
         T_DRY, T_DRY_DONE:           remaining = dry_cnt;
         default:                     remaining = '0;
      endcase
   end

   assign phase = state;

endmodule

// File: tb/tb_wash_timer.sv
// Self-checking bench for wash_timer: directed scenarios plus random input
// sequences compared against an elapsed-cycle reference model.
module tb_wash_timer;

   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 8;
   localparam int BOUND    = 300;

   logic             clk;
   logic             reset;
   logic [1:0]       prog;
   logic             clear, water_pump, drying_fan, paused;
   logic             comp_time, comp_time2;
   logic [CNT_W-1:0] remaining;
   logic [2:0]       phase;

   int n_checks = 0;
   int n_errors = 0;

   int wash_tab [4] = '{10, 20, 30, 45};
   int dry_tab  [4] = '{5, 10, 15, 20};

   // Reference model: phase number, cycles of counting spent in each phase,
   // latched preset durations and the two strobes.
   int m_ph, m_wel, m_del, m_wp, m_dp, m_c1, m_c2;

   wash_timer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .prog       (prog),
      .clear      (clear),
      .water_pump (water_pump),
      .drying_fan (drying_fan),
      .paused     (paused),
      .comp_time  (comp_time),
      .comp_time2 (comp_time2),
      .remaining  (remaining),
      .phase      (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wash_left();
      int r = m_wp - m_wel / TICK_DIV;
      return (r < 0) ? 0 : r;
   endfunction

   function automatic int dry_left();
      int r = m_dp - m_del / TICK_DIV;
      return (r < 0) ? 0 : r;
   endfunction

   function automatic int exp_remaining();
      if (m_ph >= 1 && m_ph <= 3) return wash_left();
      if (m_ph >= 4)              return dry_left();
      return 0;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_wel = 0; m_del = 0; m_c1 = 0; m_c2 = 0;
      m_wp = wash_tab[0]; m_dp = dry_tab[0];
   endtask

   task automatic model_step(input logic c, input logic p, input logic f,
                             input logic pa, input logic [1:0] pg);
      if (c) begin
         m_ph = 0; m_wel = 0; m_del = 0; m_c1 = 0; m_c2 = 0;
         m_wp = wash_tab[pg]; m_dp = dry_tab[pg];
      end else begin
         case (m_ph)
            0: if (p) begin m_ph = 1; if (!pa) m_wel++; end
               else if (f) begin m_ph = 4; m_del++; end
            1: if (wash_left() == 0) begin m_c1 = 1; m_ph = 3; end
               else if (pa || !p) m_ph = 2;
               else m_wel++;
            2: if (p && !pa) begin m_ph = 1; m_wel++; end
            3: if (f) begin m_ph = 4; m_c1 = 0; end
            4: if (dry_left() == 0) begin m_c2 = 1; m_ph = 5; end
               else if (f) m_del++;
            default: ;
         endcase
      end
   endtask

   task automatic checkOutput(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic p, input logic f,
                                input logic pa, input logic [1:0] pg);
      clear = c; water_pump = p; drying_fan = f; paused = pa; prog = pg;
      model_step(c, p, f, pa, pg);
      @(posedge clk);
      @(negedge clk);
      checkOutput("comp_time", int'(comp_time), m_c1);
      checkOutput("comp_time2", int'(comp_time2), m_c2);
      checkOutput("remaining", int'(remaining), exp_remaining());
      checkOutput("phase", int'(phase), m_ph);
   endtask

   int n, active;
   logic [1:0] rp;

   initial begin
      reset = 1'b0; prog = 2'd0; clear = 1'b0;
      water_pump = 1'b0; drying_fan = 1'b0; paused = 1'b0;
      model_reset();
      #2;
      checkOutput("reset_comp_time", int'(comp_time), 0);
      checkOutput("reset_comp_time2", int'(comp_time2), 0);
      checkOutput("reset_remaining", int'(remaining), 0);
      checkOutput("reset_phase", int'(phase), 0);
      @(negedge clk);
      reset = 1'b1;

      // Wash basic: 10 ticks of 4 cycles plus the completion cycle.
      applyStimulus(1, 0, 0, 0, 0);
      n = 0;
      do begin applyStimulus(0, 1, 0, 0, 0); n++; end
      while (!comp_time && n < BOUND);
      checkOutput("wash_basic_latency", n, 41);
      checkOutput("wash_basic_remaining", int'(remaining), 0);

      // Pause/resume with program 1.
      applyStimulus(1, 0, 0, 0, 1);
      repeat (22) applyStimulus(0, 1, 0, 0, 1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, 1, 0, 1, 1);
         checkOutput("pause_frozen", int'(remaining), 15);
      end
      active = 22;
      do begin applyStimulus(0, 1, 0, 0, 1); active++; end
      while (!comp_time && active < BOUND);
      checkOutput("pause_total_active", active, 81);

      // Dry chain with program 3.
      applyStimulus(1, 0, 0, 0, 3);
      n = 0;
      do begin applyStimulus(0, 1, 0, 0, 3); n++; end
      while (!comp_time && n < BOUND);
      checkOutput("dry_chain_wash_done", int'(comp_time), 1);
      applyStimulus(1, 0, 0, 0, 3);
      applyStimulus(0, 0, 1, 0, 3);
      checkOutput("dry_start_remaining", int'(remaining), 20);
      n = 1;
      while (!comp_time2 && n < BOUND) begin
         applyStimulus(0, 0, 1, 0, 3);
         n++;
         checkOutput("dry_comp_time_low", int'(comp_time), 0);
      end
      checkOutput("dry_latency", n, 81);

      // Clear on the cycle of the final wash tick.
      applyStimulus(1, 0, 0, 0, 0);
      repeat (39) applyStimulus(0, 1, 0, 0, 0);
      checkOutput("clr_pri_before", int'(remaining), 1);
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("clr_pri_comp", int'(comp_time), 0);
      checkOutput("clr_pri_phase", int'(phase), 0);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("clr_pri_reload", int'(remaining), 10);

      // Program changes outside clear are ignored.
      applyStimulus(1, 0, 0, 0, 0);
      n = 0;
      do begin applyStimulus(0, 1, 0, 0, (n < 5) ? 2'd0 : 2'd2); n++; end
      while (!comp_time && n < BOUND);
      checkOutput("prog_latch_latency", n, 41);
      applyStimulus(1, 0, 0, 0, 2);
      applyStimulus(0, 1, 0, 0, 2);
      checkOutput("prog_latch_reload", int'(remaining), 30);

      // Random episodes, each starting from a clear.
      for (int ep = 0; ep < 6; ep++) begin
         applyStimulus(1, 0, 0, 0, 2'($urandom_range(3, 0)));
         for (int i = 0; i < 250; i++) begin
            rp = 2'($urandom_range(3, 0));
            applyStimulus($urandom_range(199, 0) == 0,
                          $urandom_range(99, 0) < 85,
                          $urandom_range(99, 0) < 35,
                          $urandom_range(99, 0) < 8,
                          rp);
         end
      end

      // Asynchronous reset in the middle of a dry phase.
      applyStimulus(1, 0, 0, 0, 1);
      repeat (10) applyStimulus(0, 0, 1, 0, 1);
      checkOutput("pre_reset_phase", int'(phase), 4);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_comp_time", int'(comp_time), 0);
      checkOutput("async_comp_time2", int'(comp_time2), 0);
      checkOutput("async_remaining", int'(remaining), 0);
      checkOutput("async_phase", int'(phase), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
